sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//  Parametrised single-clock FIFO, successor to the fixed 4-bit FIFO behind the TT top wrapper.
//  Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty,
//  sticky overflow/underflow error flags and a selectable first-word-fall-through read mode.
//  Sits between ui_in-driven producer logic and uo_out-driven consumer logic in the tile.
// PARAMETERS
//  DATA_WIDTH  4  bits per entry
//  ADDR_WIDTH  3  log2 depth; DEPTH = 2**ADDR_WIDTH (8)
//  AF_LEVEL    6  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    2  almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//  FWFT        1  1 = first-word-fall-through read, 0 = registered read, 1-cycle latency
// PORTS
//  clk           in   1             single clock, all state on rising edge
//  rst_n         in   1             synchronous, active-low reset
//  winc          in   1             write request
//  wdata         in   DATA_WIDTH    write data, sampled with accepted write
//  rinc          in   1             read request / pop
//  rdata         out  DATA_WIDTH    read data
//  full          out  1             count == DEPTH
//  empty         out  1             count == 0
//  almost_full   out  1             count >= AF_LEVEL
//  almost_empty  out  1             count <= AE_LEVEL
//  count         out  ADDR_WIDTH+1  current occupancy 0..DEPTH
//  overflow      out  1             sticky: write refused while full
//  underflow     out  1             sticky: read refused while empty
//  clr_err       in   1             clears overflow/underflow
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): wptr=rptr=0, count=0, overflow=underflow=0, registered rdata=0.
//    Outputs after reset: empty=1, almost_empty=1, full=0, almost_full=0, rdata=0.
//    Memory array not cleared; contents unreachable. Reset mid-operation discards all entries.
//  - wr_ok = winc & ~full; rd_ok = rinc & ~empty, both evaluated on pre-edge state.
//  - wr_ok: mem[wptr] <= wdata, wptr <= wptr+1 (mod DEPTH, natural wrap).
//  - rd_ok: rptr <= rptr+1 (mod DEPTH).
//  - count: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
//  - Simultaneous winc+rinc when full: read accepted, write refused (overflow set).
//    When empty: write accepted, read refused (underflow set). No write-to-read bypass.
//  - All flags are combinational decodes of registered count; they change the cycle after the edge.
//  - FWFT=1: rdata = mem[rptr] whenever empty=0, else 0; head visible without rinc;
//    rd_ok advances to next entry visible next cycle.
//  - FWFT=0: rdata register loads mem[rptr] on rd_ok edge (valid the following cycle);
//    holds last value otherwise, including on refused reads.
//  - overflow <= 1 on winc&full; underflow <= 1 on rinc&empty; clr_err clears both;
//    set has priority over clear in the same cycle.
//  - Width rules: count is ADDR_WIDTH+1 bits so DEPTH is representable; pointers ADDR_WIDTH bits.
// TESTING
//  1 Reset then idle: rst_n=0 one edge -> count=0, empty=1, almost_empty=1, full=0, errors=0, rdata=0.
//  2 Fill: write 1..8 on consecutive cycles -> count 1..8, almost_full from count=6, full at 8;
//    9th winc -> data dropped, overflow=1, count stays 8.
//  3 Drain FWFT=1: after fill, rdata=1 with no rinc; rinc x8 -> rdata 1..8 in order, empty after 8th;
//    extra rinc -> underflow=1, clr_err next cycle -> underflow=0.
//  4 Wrap + simultaneous: keep count at 3, winc&rinc for 20 cycles with data 0..F cycling ->
//    count stays 3, output order matches input order across pointer wrap.
//  5 FWFT=0 latency: write 0xA,0xB; rinc one cycle -> rdata=0xA the next cycle, holds until next rinc.
//  6 Reset mid-operation: count=5, assert rst_n=0 with winc=1 -> count=0, empty=1, write not stored.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: parametrised single-clock FIFO with occupancy count, threshold flags, sticky errors and FWFT/registered read
//   clk          rising-edge clock for all state
//   rst_n        synchronous active-low reset
//   winc, wdata  write request and data
//   rinc         read request (pop)
//   rdata        read data (head when FWFT=1, last popped word when FWFT=0)
//   full, empty, almost_full, almost_empty  decodes of count
//   count        occupancy 0..DEPTH
//   overflow, underflow  sticky refused-write / refused-read flags
//   clr_err      clears both sticky flags (a same-cycle set wins)
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  wr_ok, rd_ok;
    assign wr_ok        = winc & ~full;
    assign rd_ok        = rinc & ~empty;
    assign full         = count == (ADDR_WIDTH+1)'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= (ADDR_WIDTH+1)'(AF_LEVEL);
    assign almost_empty = count <= (ADDR_WIDTH+1)'(AE_LEVEL);
    assign rdata        = FWFT != 0 ? (empty ? '0 : mem[rptr]) : rdata_q;
    // write gated by rst_n so a write coinciding with reset never lands
    always_ff @(posedge clk)
        if (wr_ok && rst_n) mem[wptr] <= wdata;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rdata_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) begin
                rptr    <= rptr + 1'b1;
                rdata_q <= mem[rptr];
            end
            count     <= count + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(rd_ok);
            overflow  <= (winc & full) | (overflow & ~clr_err);
            underflow <= (rinc & empty) | (underflow & ~clr_err);
        end
    end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed self-checking bench driving an FWFT and a registered-read instance with shared stimulus
module tb_sync_fifo_flags;
    logic       clk = 1'b0;
    logic       rst_n, winc, rinc, clr_err;
    logic [3:0] wdata;
    logic [3:0] rdata, r_rdata;
    logic [3:0] count, r_count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic       r_full, r_empty, r_almost_full, r_almost_empty, r_overflow, r_underflow;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_flags #(.FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(r_rdata),
        .full(r_full), .empty(r_empty), .almost_full(r_almost_full), .almost_empty(r_almost_empty),
        .count(r_count), .overflow(r_overflow), .underflow(r_underflow), .clr_err(clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [3:0] d);
        winc  = 1'b1;
        wdata = d;
        tick();
        winc  = 1'b0;
    endtask

    initial begin
        winc = 0; rinc = 0; clr_err = 0; wdata = 0;
        reset();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_r_rdata", r_rdata, 0);

        for (int i = 1; i <= 8; i++) begin
            push(4'(i));
            chk("fill_count", count, i);
            chk("fill_af", almost_full, i >= 6);
            chk("fill_ae", almost_empty, i <= 2);
            chk("fill_full", full, i == 8);
        end
        push(4'h9);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 8);

        chk("fwft_head", rdata, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_clr", overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", rdata, i);
            rinc = 1'b1;
            tick();
            rinc = 1'b0;
        end
        chk("drain_empty", empty, 1);
        chk("drain_rdata0", rdata, 0);
        chk("drain_r_rdata", r_rdata, 8);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("unf_set", underflow, 1);
        chk("unf_count", count, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("unf_clr", underflow, 0);

        for (int i = 0; i < 3; i++) push(4'(i));
        for (int c = 0; c < 20; c++) begin
            chk("wrap_data", rdata, c & 15);
            winc  = 1'b1;
            rinc  = 1'b1;
            wdata = 4'(c + 3);
            tick();
            chk("wrap_count", count, 3);
        end
        winc = 0; rinc = 0;

        reset();
        push(4'hA);
        push(4'hB);
        chk("reg_pre", r_rdata, 0);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("reg_lat", r_rdata, 4'hA);
        chk("fwft_next", rdata, 4'hB);
        tick();
        chk("reg_hold", r_rdata, 4'hA);

        reset();
        for (int i = 1; i <= 5; i++) push(4'(i));
        chk("mid_count5", count, 5);
        rst_n = 1'b0;
        winc  = 1'b1;
        wdata = 4'h7;
        tick();
        rst_n = 1'b1;
        winc  = 1'b0;
        chk("mid_count", count, 0);
        chk("mid_empty", empty, 1);
        chk("mid_rdata", rdata, 0);
        push(4'h3);
        chk("mid_after_count", count, 1);
        chk("mid_after_head", rdata, 4'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
